// File: rtl/reg_timer.sv
// ----------------------------------------------------------------------------
// reg_timer
//   Bus-side register block for the machine timer. Presents the free-running
//   64-bit mtime and the programmable mtimecmp/msip to software through a
//   32-bit valid/ready request/response bus, with tear-free 64-bit access:
//     - reading MTIME_LO snapshots mtime[63:32]; MTIME_HI returns the snapshot
//     - writing MTIMECMP_LO only loads a shadow; writing MTIMECMP_HI commits
//       {hi, shadow} to mtimecmp in a single edge
//
//   Register map (byte address, word index req_addr[4:2]):
//     0 MTIME_LO    RO   mtime[31:0], latches mtime[63:32] into the snapshot
//     1 MTIME_HI    RO   snapshot of mtime[63:32]
//     2 MTIMECMP_LO RW   read: committed mtimecmp[31:0]; write: shadow only
//     3 MTIMECMP_HI RW   write commits {hi merged by req_be, shadow}
//     4 MSIP        RW   bit 0
//     5 STATUS      RO   {30'b0, msip, int_timer}
//     6-7           error
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready = !rsp_valid | rsp_ready)
//   req_we, req_addr,
//   req_be, req_wdata       request payload
//   rsp_valid/rsp_ready     response handshake (single-entry buffer)
//   rsp_rdata, rsp_err      response payload, stable while rsp_valid & !rsp_ready
//   mtime, int_timer        from fnc_timer
//   mtimecmp, msip          to fnc_timer / interrupt logic
// ----------------------------------------------------------------------------
module reg_timer #(
  parameter int          ADDR_W    = 5,
  parameter logic [63:0] CMP_RESET = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic [63:0]       mtime,
  input  logic              int_timer,
  output logic [63:0]       mtimecmp,
  output logic              msip
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_MSIP     = 3'd4,
    REG_STATUS   = 3'd5
  } reg_idx_e;

  // Byte-lane merge: lanes with be set take the new data, others keep old.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] cmp_lo_shadow;
  logic [31:0] mtime_hi_snap;

  reg_idx_e    idx;
  logic        accept;

  // Decoded response and write strobes for the request currently offered.
  logic [31:0] dec_rdata;
  logic        dec_err;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_msip;
  logic        snap_en;

  // A new request may load the buffer when it is empty or being drained.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign idx       = reg_idx_e'(req_addr[4:2]);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves one unassigned (which would be a latch).
    dec_rdata = 32'h0;
    dec_err   = 1'b0;
    wr_cmp_lo = 1'b0;
    wr_cmp_hi = 1'b0;
    wr_msip   = 1'b0;
    snap_en   = 1'b0;

    if (req_addr[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else begin
      unique case (idx)
        REG_MTIME_LO: begin
          if (req_we) dec_err = 1'b1;
          else begin
            dec_rdata = mtime[31:0];
            snap_en   = 1'b1;
          end
        end
        REG_MTIME_HI: begin
          if (req_we) dec_err   = 1'b1;
          else        dec_rdata = mtime_hi_snap;
        end
        REG_CMP_LO: begin
          // Reads return the committed value, never the pending shadow.
          if (req_we) wr_cmp_lo = |req_be;
          else        dec_rdata = mtimecmp[31:0];
        end
        REG_CMP_HI: begin
          // An all-zero byte enable is a no-op, so it must not commit the shadow.
          if (req_we) wr_cmp_hi = |req_be;
          else        dec_rdata = mtimecmp[63:32];
        end
        REG_MSIP: begin
          if (req_we) wr_msip   = req_be[0];
          else        dec_rdata = {31'b0, msip};
        end
        REG_STATUS: begin
          if (req_we) dec_err   = 1'b1;
          else        dec_rdata = {30'b0, msip, int_timer};
        end
        default: dec_err = 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Architectural state: side effects commit on the acceptance edge
  // --------------------------------------------------------------------------
  // NOTE: this block holds only a handful of flops (no storage array), so every
  // one of them is given a defined value by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp      <= CMP_RESET;
      cmp_lo_shadow <= CMP_RESET[31:0];
      msip          <= 1'b0;
      mtime_hi_snap <= 32'h0;
    end else if (accept) begin
      // NOTE: non-blocking assignments here mean the CMP_HI commit below sees
      // the shadow value from before this edge, like every other reader.
      if (wr_cmp_lo) cmp_lo_shadow <= be_merge(cmp_lo_shadow, req_wdata, req_be);
      if (wr_cmp_hi) mtimecmp      <= {be_merge(mtimecmp[63:32], req_wdata, req_be),
                                       cmp_lo_shadow};
      if (wr_msip)   msip          <= req_wdata[0];
      if (snap_en)   mtime_hi_snap <= mtime[63:32];
    end
  end

  // --------------------------------------------------------------------------
  // Single-entry response buffer
  // --------------------------------------------------------------------------
  // A new acceptance overwrites the buffer even when the old response retires
  // on the same edge; otherwise a consumed response simply drops valid and the
  // payload is left as-is (it is only meaningful while rsp_valid is high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= dec_rdata;
      rsp_err   <= dec_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_timer.sv
// ----------------------------------------------------------------------------
// tb_reg_timer
//   Scoreboard bench for reg_timer. The driver offers requests and, at the
//   moment a request is about to be accepted, asks a behavioural model of the
//   register map for the expected response and pushes it into a queue. An
//   independent monitor pops and compares whenever a response is consumed.
//   int_timer is produced here as a stand-in for fnc_timer (mtime >= mtimecmp).
// ----------------------------------------------------------------------------
module tb_reg_timer;

  localparam logic [63:0] CMP_RESET = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mtime = '0;
  logic        int_timer;
  logic [63:0] mtimecmp;
  logic        msip;

  reg_timer #(.ADDR_W(5), .CMP_RESET(CMP_RESET)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mtime     (mtime),
    .int_timer (int_timer),
    .mtimecmp  (mtimecmp),
    .msip      (msip)
  );

  always #5 clk = ~clk;

  assign int_timer = (mtime >= mtimecmp);

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rsp_count = 0;
  int   stall_cnt = 0;
  bit   rand_ready = 1'b0;

  // Behavioural model of the software-visible state.
  logic [63:0] model_cmp    = CMP_RESET;
  logic [31:0] model_shadow = CMP_RESET[31:0];
  logic        model_msip   = 1'b0;
  logic [31:0] model_snap   = 32'h0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    model_cmp    = CMP_RESET;
    model_shadow = CMP_RESET[31:0];
    model_msip   = 1'b0;
    model_snap   = 32'h0;
  endtask

  // Apply one access to the model; returns the response software should see.
  task automatic model_access(input logic we, input logic [4:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              output exp_t e);
    int          idx;
    logic [31:0] word;
    idx = int'(addr[4:2]);
    e   = '0;
    if (addr[1:0] != 2'b00 || idx > 5 || (we && (idx == 0 || idx == 1 || idx == 5))) begin
      e.err = 1'b1;
    end else if (!we) begin
      case (idx)
        0: begin e.rdata = mtime[31:0]; model_snap = mtime[63:32]; end
        1: e.rdata = model_snap;
        2: e.rdata = model_cmp[31:0];
        3: e.rdata = model_cmp[63:32];
        4: e.rdata = {31'b0, model_msip};
        default: e.rdata = {30'b0, model_msip, (mtime >= model_cmp)};
      endcase
    end else begin
      case (idx)
        2: for (int b = 0; b < 4; b++)
             if (be[b]) model_shadow[8*b +: 8] = wdata[8*b +: 8];
        3: if (be != 4'b0) begin
             word = model_cmp[63:32];
             for (int b = 0; b < 4; b++)
               if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
             model_cmp = {word, model_shadow};
           end
        default: if (be[0]) model_msip = wdata[0];
      endcase
    end
  endtask

  // Called between posedge+1 and the next negedge. Returns posedge+1 after
  // the edge that accepted the request; waits = cycles spent with req_ready=0.
  task automatic do_req(input logic we, input logic [4:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output int waits);
    exp_t e;
    bit   ok;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    waits     = 0;
    ok        = 1'b0;
    while (!ok && waits <= 50) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: req_ready stayed 0 for %0d cycles, required 1", waits);
      req_valid = 1'b0;
    end else begin
      model_access(we, addr, be, wdata, e);
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [4:0] addr);
    int w;
    do_req(1'b0, addr, 4'h0, 32'h0, w);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [3:0] be, input logic [31:0] d);
    int w;
    do_req(1'b1, addr, be, d, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response consumer: ready is updated at posedge+2 so the driver's own
  // updates of stall_cnt at posedge+1 are always seen.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stall_cnt > 0) begin
        rsp_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      else                     rsp_ready = 1'b1;
    end
  end

  // Monitor: a response is consumed on the edge following a negedge where
  // rsp_valid & rsp_ready holds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        rsp_count++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got rdata %h err %0d, required no response",
                   rsp_rdata, rsp_err);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
          check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
        end
      end
    end
  end

  initial begin
    int w;
    int base;
    int guard;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("reset_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
    check("reset_rsp_err", {63'h0, rsp_err}, 64'h0);
    check("reset_mtimecmp", mtimecmp, CMP_RESET);
    check("reset_msip", {63'h0, msip}, 64'h0);
    rst_n = 1'b1;
    idle(1);
    check("reset_req_ready", {63'h0, req_ready}, 64'h1);
    rd(5'h04);                                   // snapshot starts at 0

    // ---------------- mtime tear-free read ----------------
    mtime = 64'h1_FFFF_FFFE;
    rd(5'h00);                                   // FFFF_FFFE, snap=1
    mtime = 64'h2_0000_0001;
    rd(5'h04);                                   // 1 (snapshot, not live 2)
    rd(5'h00);                                   // 0000_0001
    rd(5'h04);                                   // 0000_0002

    // ---------------- mtimecmp shadow/commit ----------------
    mtime = 64'h0;
    wr(5'h08, 4'hF, 32'h10);
    check("cmp_lo_shadow_only", mtimecmp, 64'h0);
    rd(5'h08);                                   // committed lo is still 0
    wr(5'h0C, 4'hF, 32'h0);
    check("cmp_hi_commit", mtimecmp, 64'h10);
    mtime = 64'd16;
    rd(5'h14);                                   // int_timer=1
    mtime = 64'd17;
    rd(5'h14);
    wr(5'h08, 4'hF, 32'd100);
    wr(5'h0C, 4'hF, 32'h0);
    check("cmp_rewrite", mtimecmp, 64'd100);
    rd(5'h14);                                   // int_timer=0

    // ---------------- byte enables ----------------
    wr(5'h0C, 4'hF, 32'hAABB_CCDD);
    wr(5'h0C, 4'b0101, 32'h1122_3344);
    check("cmp_hi_be_merge", {32'h0, mtimecmp[63:32]}, {32'h0, 32'hAA22_CC44});
    check("cmp_model", mtimecmp, model_cmp);
    wr(5'h0C, 4'h0, 32'hFFFF_FFFF);              // be=0: no change
    wr(5'h08, 4'b0010, 32'h0000_5500);
    wr(5'h0C, 4'b1000, 32'h7700_0000);
    check("cmp_lo_be_merge", mtimecmp, model_cmp);
    rd(5'h0C);
    rd(5'h08);
    wr(5'h10, 4'h1, 32'hFFFF_FFFF);              // msip=1
    check("msip_set", {63'h0, msip}, 64'h1);
    wr(5'h10, 4'hE, 32'h0);                      // be[0]=0: msip stays
    check("msip_be0_ignored", {63'h0, msip}, 64'h1);
    rd(5'h10);
    rd(5'h14);

    // ---------------- backpressure ----------------
    rd(5'h08);
    stall_cnt = 3;
    do_req(1'b0, 5'h0C, 4'h0, 32'h0, w);
    check("stall_req_ready_waits", 64'(w), 64'd3);
    idle(1);
    base = rsp_count;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 5'(i * 4), 4'h0, 32'h0, w);
      check("b2b_no_wait", 64'(w), 64'd0);
    end
    idle(2);
    check("b2b_rsp_count", 64'(rsp_count - base), 64'd4);

    // ---------------- errors ----------------
    mtime = 64'hDEAD_0000_1234_5678;
    rd(5'h00);                                   // snap = DEAD_0000
    mtime = 64'h0BAD_F00D_0000_0000;
    rd(5'h02);
    rd(5'h01);                                   // misaligned LO: no snapshot
    rd(5'h18);
    rd(5'h1C);
    wr(5'h00, 4'hF, 32'h1234_5678);
    wr(5'h04, 4'hF, 32'h1234_5678);
    wr(5'h14, 4'hF, 32'hFFFF_FFFF);
    wr(5'h0E, 4'hF, 32'hFFFF_FFFF);              // misaligned CMP_HI write
    check("err_no_cmp_change", mtimecmp, model_cmp);
    check("err_no_msip_change", {63'h0, msip}, 64'h1);
    rd(5'h04);                                   // still DEAD_0000

    // ---------------- randomized traffic ----------------
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [4:0] a;
      case ($urandom_range(0, 3))
        0: mtime = {$urandom, $urandom};
        1: mtime = mtime + 64'($urandom_range(0, 3));
        2: mtime = model_cmp + 64'($urandom_range(0, 2)) - 64'd1;
        default: ;
      endcase
      a = {3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_req(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, w);
      if (i % 25 == 0) check("rand_cmp_model", mtimecmp, model_cmp);
    end
    rand_ready = 1'b0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    check("rand_final_cmp", mtimecmp, model_cmp);
    check("rand_final_msip", {63'h0, msip}, {63'h0, model_msip});

    // ---------------- reset mid-response ----------------
    wr(5'h10, 4'h1, 32'h1);
    wr(5'h08, 4'hF, 32'h5);
    wr(5'h0C, 4'hF, 32'h7);
    rd(5'h14);
    stall_cnt = 20;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_mid_mtimecmp", mtimecmp, CMP_RESET);
    check("rst_mid_msip", {63'h0, msip}, 64'h0);
    sb_q.delete();
    model_reset();
    stall_cnt = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(1);
    rd(5'h04);                                   // snapshot back to 0
    rd(5'h08);
    wr(5'h0C, 4'hF, 32'h1);                      // shadow was reset too
    check("rst_shadow_cleared", mtimecmp, 64'h1_0000_0000);
    idle(3);
    check("final_queue_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
